ram_seq_ctrl: RTL and testbench
===============================

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Parameter: READ_LAT, default 1, cycles from ram_addr registered to ram_q valid (legal 1 or 2).
REQ-002 Parameter: FILL_VALUE, default 4'h0, nibble written to every location by a fill sequence.
REQ-003 Port: clock  in  1  single block clock, rising-edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req_valid  in  1  host request present.
REQ-006 Port: req_we  in  1  1 = write, 0 = read.
REQ-007 Port: req_addr  in  5  target address 0..31.
REQ-008 Port: req_data  in  4  write data.
REQ-009 Port: req_ready  out  1  request accepted when req_valid && req_ready.
REQ-010 Port: clear_start  in  1  start a fill of all 32 locations.
REQ-011 Port: scan_start  in  1  start a read-out of all 32 locations.
REQ-012 Port: busy  out  1  high while FILL or SCAN is in progress.
REQ-013 Port: done  out  1  one-cycle pulse when FILL or SCAN completes.
REQ-014 Port: rsp_valid  out  1  one-cycle pulse marking rsp_addr/rsp_data valid.
REQ-015 Port: rsp_addr  out  5  address of returned data.
REQ-016 Port: rsp_data  out  4  returned nibble.
REQ-017 Port: ram_addr  out  5  registered, to ram32x4 address.
REQ-018 Port: ram_data  out  4  registered, to ram32x4 data.
REQ-019 Port: ram_wren  out  1  registered, to ram32x4 wren.
REQ-020 Port: ram_q  in  4  from ram32x4 q.

Function
REQ-021 FSM states: IDLE, RD_WAIT, FILL, SCAN_RD, SCAN_WAIT; req_ready = 1 only in IDLE.
REQ-022 IDLE priority per cycle: clear_start > scan_start > req_valid; lower-priority inputs that cycle are dropped.
REQ-023 Write accepted at edge N: ram_addr=req_addr, ram_data=req_data, ram_wren=1 after edge N for exactly one cycle; FSM stays IDLE.
REQ-024 Read accepted at edge N: ram_addr=req_addr after N, ram_wren=0; RD_WAIT for READ_LAT cycles; ram_q sampled at edge N+READ_LAT+1, after which rsp_valid=1 for one cycle with rsp_addr=req_addr; then IDLE.
REQ-025 FILL: 5-bit counter 0..31, one write per cycle, ram_data=FILL_VALUE, ram_wren=1 for 32 consecutive cycles; after address 31, wren drops, done pulses, IDLE.
REQ-026 SCAN: for addresses 0..31 in order, issue a read (SCAN_RD), wait READ_LAT (SCAN_WAIT), emit rsp_valid with rsp_addr/rsp_data; after address 31 response, done pulses with it, IDLE.
REQ-027 Counter reaching 31 terminates the sequence; it never wraps to 0 and continues.
REQ-028 busy=1 in FILL, SCAN_RD, SCAN_WAIT; 0 otherwise; clear_start/scan_start/req_valid ignored while busy or in RD_WAIT.
REQ-029 rsp_valid and done have no backpressure; consumer must capture in the pulse cycle.
REQ-030 ram_wren is 0 in every state except the single write cycle and FILL.

Reset
REQ-031 On reset: state IDLE, ram_addr=0, ram_data=0, ram_wren=0, rsp_valid=0, rsp_addr=0, rsp_data=0, busy=0, done=0, counter=0.
REQ-032 Reset asserted mid-FILL or mid-SCAN aborts at the next edge: ram_wren=0, no done pulse, sequence not resumed.
REQ-033 req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-034 Macro RAM_SEQ_CTRL_SCAN_EN: defined -> SCAN states and scan_start behave per REQ-026.
REQ-035 Macro undefined -> scan_start port remains but is ignored, SCAN states unreachable, done pulses only for FILL.

Verification
REQ-036 Write addr 5 data 4'hA, read addr 5 -> rsp_valid one cycle, rsp_addr=5, rsp_data=4'hA, exactly READ_LAT+1 cycles after read accept.
REQ-037 clear_start with FILL_VALUE=4'h3 -> 32 consecutive wren cycles, addresses 0..31, busy 32 cycles, done once; subsequent reads of 0, 17, 31 return 4'h3.
REQ-038 Write addr n data n[3:0] for n=0..31, scan_start (macro defined) -> 32 rsp_valid pulses, rsp_addr 0..31 in order, rsp_data=rsp_addr[3:0], done coincident with addr 31.
REQ-039 clear_start and req_valid (write addr 2 data 4'hF) in same cycle -> fill wins, write dropped, addr 2 reads FILL_VALUE.
REQ-040 reset asserted at fill address 10 -> ram_wren=0 next cycle, no done, req_ready=1 after release; address 20 retains prior contents.
REQ-041 Macro undefined, scan_start pulse -> no rsp_valid, busy stays 0, req_ready stays 1.

Source files
------------

// File: rtl/ram_seq_ctrl.sv
// Sequencer for an external 32x4 RAM: host single reads/writes, full fill, full scan.
// Define RAM_SEQ_CTRL_SCAN_EN to enable the scan (read-out of all 32 locations).
module ram_seq_ctrl #(
  parameter int         READ_LAT   = 1,
  parameter logic [3:0] FILL_VALUE = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [4:0] req_addr,
  input  logic [3:0] req_data,
  output logic       req_ready,
  input  logic       clear_start,
  input  logic       scan_start,
  output logic       busy,
  output logic       done,
  output logic       rsp_valid,
  output logic [4:0] rsp_addr,
  output logic [3:0] rsp_data,
  output logic [4:0] ram_addr,
  output logic [3:0] ram_data,
  output logic       ram_wren,
  input  logic [3:0] ram_q
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_WAIT   = 3'd1;
  localparam logic [2:0] FILL      = 3'd2;
  localparam logic [2:0] SCAN_RD   = 3'd3;
  localparam logic [2:0] SCAN_WAIT = 3'd4;

  localparam logic [1:0] LAT = 2'(READ_LAT);

  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [4:0] ram_addr_q, ram_addr_d;
  logic [3:0] ram_data_q, ram_data_d;
  logic       ram_wren_q, ram_wren_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [4:0] rsp_addr_q, rsp_addr_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       done_q, done_d;

`ifndef RAM_SEQ_CTRL_SCAN_EN
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_wren_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d    = FILL;
          cnt_d      = 5'd0;
          ram_addr_d = 5'd0;
          ram_data_d = FILL_VALUE;
          ram_wren_d = 1'b1;
`ifdef RAM_SEQ_CTRL_SCAN_EN
        end else if (scan_start) begin
          state_d = SCAN_RD;
          cnt_d   = 5'd0;
`endif
        end else if (req_valid) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_data_d = req_data;
            ram_wren_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
            wcnt_d  = 2'd0;
          end
        end
      end
      // ram_addr_q still holds the host address here
      RD_WAIT: begin
        if (wcnt_q == LAT) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = ram_addr_q;
          rsp_data_d  = ram_q;
          state_d     = IDLE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      FILL: begin
        if (cnt_q == 5'd31) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d      = cnt_q + 5'd1;
          ram_addr_d = cnt_q + 5'd1;
          ram_data_d = FILL_VALUE;
          ram_wren_d = 1'b1;
        end
      end
`ifdef RAM_SEQ_CTRL_SCAN_EN
      SCAN_RD: begin
        ram_addr_d = cnt_q;
        wcnt_d     = 2'd0;
        state_d    = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        if (wcnt_q == LAT) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = cnt_q;
          rsp_data_d  = ram_q;
          if (cnt_q == 5'd31) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = SCAN_RD;
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      wcnt_q      <= 2'd0;
      ram_addr_q  <= 5'd0;
      ram_data_q  <= 4'd0;
      ram_wren_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 5'd0;
      rsp_data_q  <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wren_q  <= ram_wren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == FILL) || (state_q == SCAN_RD) ||
                     (state_q == SCAN_WAIT);
  assign done      = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Scoreboard bench for ram_seq_ctrl with a behavioural 32x4 RAM model.
// Scan checks run when RAM_SEQ_CTRL_SCAN_EN is defined.
module tb_ram_seq_ctrl;

  localparam int         LAT = 1;
  localparam logic [3:0] FV  = 4'h3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [3:0] req_data = '0;
  logic       clear_start = 1'b0, scan_start = 1'b0;
  logic       req_ready, busy, done, rsp_valid, ram_wren;
  logic [4:0] rsp_addr, ram_addr;
  logic [3:0] rsp_data, ram_data, ram_q;

  ram_seq_ctrl #(.READ_LAT(LAT), .FILL_VALUE(FV)) dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .clear_start(clear_start), .scan_start(scan_start),
    .busy(busy), .done(done),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [32];
  logic [3:0] q1, q2;
  initial for (int i = 0; i < 32; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    q1 <= mem[ram_addr];
    q2 <= q1;
  end
  assign ram_q = (LAT == 1) ? q1 : q2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit scan_chk = 1'b0;

  typedef struct {
    logic [4:0] a;
    logic [3:0] d;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got addr %0d data %0h expected none",
                 rsp_addr, rsp_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_addr", 32'(rsp_addr), 32'(e.a));
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
        if (scan_chk) chk("scan_done", 32'(done), 32'(rsp_addr == 5'd31));
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_port", {22'd0, ram_wren, ram_addr, ram_data}, {22'd0, 1'b1, a, d});
  endtask

  task automatic rd(input logic [4:0] a, input logic [3:0] e);
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'd1);
    sbq.push_back('{a: a, d: e, cyc: cyc + LAT + 2});
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic wait_done(input string n);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      clear_start = 1'b0; req_valid = 1'b0;
      if (done) seen = 1'b1;
    end
    chk(n, 32'(seen), 32'd1);
  endtask

  initial begin
    int wr_n, busy_n, done_n, idx;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_ram", {23'd0, ram_wren, ram_addr, ram_data}, 32'd0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_addr, rsp_data}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'd1);

    wr(5'd5, 4'hA);
    @(negedge clk);
    chk("wr_one_cycle", 32'(ram_wren), 32'd0);
    rd(5'd5, 4'hA);

    @(negedge clk);
    clear_start = 1'b1;
    wr_n = 0; busy_n = 0; done_n = 0; idx = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      clear_start = 1'b0;
      if (ram_wren) begin
        chk("fill_wr", {23'd0, ram_addr, ram_data}, {23'd0, 5'(idx), FV});
        idx++;
        wr_n++;
      end
      if (busy) busy_n++;
      if (done) done_n++;
    end
    chk("fill_wren_cnt", wr_n, 32);
    chk("fill_busy_cnt", busy_n, 32);
    chk("fill_done_cnt", done_n, 1);
    rd(5'd0, FV);
    rd(5'd17, FV);
    rd(5'd31, FV);

    wr(5'd2, 4'h9);
    @(negedge clk);
    clear_start = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd2; req_data = 4'hF;
    wait_done("prio_fill_done");
    rd(5'd2, FV);

    wr(5'd20, 4'h7);
    @(negedge clk);
    clear_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      clear_start = 1'b0;
      if (ram_wren && ram_addr == 5'd10) found = 1'b1;
    end
    chk("abort_reach10", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wren", {30'd0, ram_wren, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {30'd0, req_ready, busy}, {30'd0, 2'b10});
    done_n = 0; busy_n = 0; wr_n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
      if (ram_wren) wr_n++;
    end
    chk("abort_quiet", done_n + busy_n + wr_n, 0);
    rd(5'd20, 4'h7);

`ifdef RAM_SEQ_CTRL_SCAN_EN
    for (int n = 0; n < 32; n++) wr(5'(n), 4'(n));
    @(negedge clk);
    scan_chk = 1'b1;
    for (int n = 0; n < 32; n++)
      sbq.push_back('{a: 5'(n), d: 4'(n), cyc: -1});
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int i = 0; i < 32 * (LAT + 3) + 20 && sbq.size() != 0; i++)
      @(negedge clk);
    chk("scan_drain", sbq.size(), 0);
    @(negedge clk);
    scan_chk = 1'b0;
    chk("scan_idle", {30'd0, req_ready, busy}, {30'd0, 2'b10});
`else
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    busy_n = 0; idx = 0;
    repeat (12) begin
      if (busy) busy_n++;
      if (!req_ready) idx++;
      @(negedge clk);
    end
    chk("noscan_busy", busy_n, 0);
    chk("noscan_ready", idx, 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
